// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: prescaled countdown sequencer built as a Moore FSM (IDLE/RUN/PAUSE/DONE).
// Define COUNT_SEQ_AUTO_RELOAD_EN to reload from load_val in DONE instead of returning to IDLE.
module count_seq_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0]       PRESC_MAX = 8'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [7:0]       presc_q, presc_d;
   logic             tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
      end
   end

   assign tick = (presc_q == PRESC_MAX);

   // A paused sequence that sees pause low behaves like a RUN cycle, so the held
   // prescaler keeps counting on the resume edge and a pause costs exactly its length.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      if (abort) begin
         state_d = IDLE;
         count_d = '0;
         presc_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  presc_d = '0;
                  if (load_val != '0) begin
                     count_d = load_val;
                     state_d = RUN;
                  end else begin
                     count_d = '0;
                     state_d = DONE;
                  end
               end
            end
            RUN, PAUSE: begin
               if (pause) begin
                  state_d = PAUSE;
               end else begin
                  state_d = RUN;
                  if (tick) begin
                     presc_d = '0;
                     if (count_q <= ONE) begin
                        count_d = '0;
                        state_d = DONE;
                     end else begin
                        count_d = count_q - ONE;
                     end
                  end else begin
                     presc_d = presc_q + 8'd1;
                  end
               end
            end
            DONE: begin
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
               presc_d = '0;
               if (load_val != '0) begin
                  count_d = load_val;
                  state_d = RUN;
               end else begin
                  count_d = '0;
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
               presc_d = '0;
            end
         endcase
      end
   end

   assign count = count_q;
   assign state = state_q;
   assign busy  = (state_q == RUN) || (state_q == PAUSE);
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: two instances (PRESCALE 1 and 3) share stimulus and are
// checked against a model that tracks run cycles elapsed rather than a prescaler register.
module tb_count_seq_ctrl;

   localparam int WIDTH  = 4;
   localparam int P_FAST = 1;
   localparam int P_SLOW = 3;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] load_val = '0;

   logic [WIDTH-1:0] count_f, count_s;
   logic [1:0]       state_f, state_s;
   logic             busy_f, busy_s, done_f, done_s;

   typedef struct {
      int mode;
      int load;
      int elapsed;
   } model_t;

   typedef struct packed {
      logic [1:0]       st;
      logic [WIDTH-1:0] cnt;
      logic             busy;
      logic             done;
   } obs_t;

   typedef struct {
      obs_t f;
      obs_t s;
   } exp_t;

   exp_t   sb[$];
   model_t m_fast, m_slow;
   int     vectors = 0;
   int     miscompares = 0;

   count_seq_ctrl #(.WIDTH(WIDTH), .PRESCALE(P_FAST)) dut_fast (
      .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
      .load_val(load_val), .count(count_f), .state(state_f), .busy(busy_f), .done(done_f)
   );

   count_seq_ctrl #(.WIDTH(WIDTH), .PRESCALE(P_SLOW)) dut_slow (
      .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
      .load_val(load_val), .count(count_s), .state(state_s), .busy(busy_s), .done(done_s)
   );

   always #5 clk = ~clk;

   // Sequence finishes once load*p unpaused run cycles have elapsed; count is derived from that.
   function automatic model_t model_next(input model_t m, input int p, input logic st,
                                         input logic pa, input logic ab, input logic [WIDTH-1:0] lv);
      model_t n;
      n = m;
      if (ab) begin
         n.mode = 0; n.load = 0; n.elapsed = 0;
      end else begin
         case (m.mode)
            0: if (st) begin
               n.elapsed = 0;
               if (lv != '0) begin n.mode = 1; n.load = int'(lv); end
               else begin n.mode = 3; n.load = 0; end
            end
            1, 2: if (pa) n.mode = 2;
               else begin
                  n.mode = 1;
                  n.elapsed = m.elapsed + 1;
                  if (n.elapsed >= m.load * p) n.mode = 3;
               end
            default: begin
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
               n.elapsed = 0;
               if (lv != '0) begin n.mode = 1; n.load = int'(lv); end
               else begin n.mode = 0; n.load = 0; end
`else
               n.mode = 0; n.load = 0; n.elapsed = 0;
`endif
            end
         endcase
      end
      return n;
   endfunction

   function automatic obs_t model_obs(input model_t m, input int p);
      obs_t o;
      o.st   = 2'(m.mode);
      o.busy = (m.mode == 1) || (m.mode == 2);
      o.done = (m.mode == 3);
      o.cnt  = o.busy ? WIDTH'(m.load - m.elapsed / p) : '0;
      return o;
   endfunction

   task automatic applyStimulus(input logic st, input logic pa, input logic ab,
                                input logic [WIDTH-1:0] lv);
      exp_t e;
      start = st; pause = pa; abort = ab; load_val = lv;
      m_fast = model_next(m_fast, P_FAST, st, pa, ab, lv);
      m_slow = model_next(m_slow, P_SLOW, st, pa, ab, lv);
      e.f = model_obs(m_fast, P_FAST);
      e.s = model_obs(m_slow, P_SLOW);
      sb.push_back(e);
      @(negedge clk);
   endtask

   // One entry is checked right after reset_n falls, one after the posedge it spans.
   task automatic resetPulse();
      exp_t e;
      start = 1'b0; pause = 1'b0; abort = 1'b0; load_val = '0;
      m_fast = '{0, 0, 0};
      m_slow = '{0, 0, 0};
      e.f = model_obs(m_fast, P_FAST);
      e.s = model_obs(m_slow, P_SLOW);
      sb.push_back(e);
      sb.push_back(e);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic checkOutput(input exp_t e);
      vectors++;
      if ({state_f, count_f, busy_f, done_f} !== e.f) begin
         miscompares++;
         $display("[TB] FAIL vec%0d p1: got st=%0d cnt=%0d busy=%0b done=%0b, want st=%0d cnt=%0d busy=%0b done=%0b",
                  vectors, state_f, count_f, busy_f, done_f, e.f.st, e.f.cnt, e.f.busy, e.f.done);
      end
      vectors++;
      if ({state_s, count_s, busy_s, done_s} !== e.s) begin
         miscompares++;
         $display("[TB] FAIL vec%0d p3: got st=%0d cnt=%0d busy=%0b done=%0b, want st=%0d cnt=%0d busy=%0b done=%0b",
                  vectors, state_s, count_s, busy_s, done_s, e.s.st, e.s.cnt, e.s.busy, e.s.done);
      end
   endtask

   // Monitor: every clock edge (and every reset assertion) presents an output to check.
   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         #1;
         if (sb.size() > 0) checkOutput(sb.pop_front());
      end
   end

   initial begin
      logic             r_st, r_pa, r_ab;
      logic [WIDTH-1:0] r_lv;
      m_fast = '{0, 0, 0};
      m_slow = '{0, 0, 0};
      @(negedge clk);
      resetPulse();

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
      idleCycles(20);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
      idleCycles(10);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      idleCycles(3);

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd4);
      idleCycles(2);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      idleCycles(15);

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd3);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd1);
      idleCycles(35);

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      idleCycles(8);

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd6);
      idleCycles(2);
      resetPulse();
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd3);
      idleCycles(12);

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd3);
      repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 4'd3);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
      idleCycles(3);

      repeat (400) begin
         if ($urandom_range(0, 99) == 0) begin
            resetPulse();
         end else begin
            r_st = ($urandom_range(0, 3) == 0);
            r_pa = ($urandom_range(0, 5) == 0);
            r_ab = ($urandom_range(0, 24) == 0);
            r_lv = WIDTH'($urandom_range(0, 15));
            applyStimulus(r_st, r_pa, r_ab, r_lv);
         end
      end
      idleCycles(5);

      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
